if_stage: RTL and testbench
===========================

# if_stage

Instruction-fetch stage of the 5-stage MIPS32 pipeline. Holds the program counter, drives the word address into the combinational instruction ROM and takes back the instruction word in the same cycle. Selects the next PC from the sequential, jump or branch path, and owns the IF/ID pipeline register. Also keeps a fetch counter for debug.

## Interface
- RESET_PC, 32'h0040_0000, PC value loaded on reset; the ROM decodes only Addr[9:2].
- clk  in  1  pipeline clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- Stall  in  1  from the hazard unit; holds the PC and IF/ID (load-use).
- Jump_En  in  1  jump resolved in ID (j/jal/jr/jalr; target mux is upstream).
- Jump_Target  in  32  jump destination.
- Branch_Taken  in  1  taken branch resolved in EX.
- Branch_Target  in  32  branch destination.
- Inst_Addr  out  32  current PC, sent to ROM Addr.
- Inst_In  in  32  instruction word returned by the ROM, combinational from Inst_Addr.
- IF_ID_Inst  out  32  registered instruction for ID.
- IF_ID_PC_Plus4  out  32  registered PC+4 of that instruction.
- IF_ID_Valid  out  1  high when IF_ID_Inst is a real fetched instruction, low for a bubble.
- Fetch_Count  out  32  number of instructions latched valid into IF/ID.

## Operation
- PC register drives Inst_Addr directly, with no output logic. PC+4 uses 32-bit wrapping addition. No delay slots.
- Next-state priority per edge, highest first:
  - reset: PC=RESET_PC; IF_ID_Inst=0; IF_ID_PC_Plus4=0; IF_ID_Valid=0; Fetch_Count=0.
  - Branch_Taken: PC={Branch_Target[31:2],2'b00}; IF/ID loads a bubble (Inst=0, PC_Plus4=0, Valid=0). This path overrides Stall, because the branch in EX is older than the stalled instruction in ID.
  - Stall: PC, IF/ID and Fetch_Count all hold. Jump_En is ignored, because the jump is the stalled instruction in ID and the hazard unit re-presents it.
  - Jump_En: PC={Jump_Target[31:2],2'b00}; IF/ID loads a bubble (squashes the sequentially fetched instruction).
  - Default: PC=PC+4; IF_ID_Inst=Inst_In; IF_ID_PC_Plus4=PC+4; IF_ID_Valid=1; Fetch_Count+1.
- Fetch_Count increments only on the default path and wraps from 32'hFFFF_FFFF to 0.
- Target bits [1:0] are always forced to 0. No misalignment exception is raised.
- PC wrap: 32'hFFFF_FFFC+4 becomes 0 with no special handling.

## Timing
- Fetch latency is one cycle: the instruction at PC in cycle N appears on IF_ID_Inst after the edge ending cycle N.
- Redirect penalties:
  - Branch: 2 bubbles total. One is inserted here; the ID-side squash belongs to the ID/EX register.
  - Jump: 1 bubble.
- Stall takes effect on the same edge it is sampled. There is no extra hold cycle after Stall falls.
- Reset is sampled on the edge. A reset asserted mid-stream overrides any simultaneous Branch_Taken, Jump_En or Stall. The first fetch at RESET_PC happens in the cycle after reset deasserts.
- All outputs are registered, except that Inst_Addr is the PC register itself.

## Test plan
- Reset and free run: hold reset 2 cycles, then release; ROM returns Inst_In=Addr. Inst_Addr must go 0x00400000, 0x00400004, 0x00400008. After the first edge: IF_ID_Inst=0x00400000, IF_ID_PC_Plus4=0x00400004, Valid=1, Fetch_Count=1.
- Stall hold: assert Stall for 2 cycles while PC=0x0040000C. Inst_Addr, IF_ID_* and Fetch_Count stay unchanged for both cycles. PC=0x00400010 on the first edge after Stall falls.
- Branch over stall: Stall=1 and Branch_Taken=1 with Branch_Target=0x00400043. Next PC=0x00400040, IF_ID_Valid=0, IF_ID_Inst=0, Fetch_Count unchanged.
- Jump gating: Jump_En=1 with Jump_Target=0x00400034 and Stall=1, so the PC holds. Next cycle Stall=0, so PC=0x00400034 and IF/ID is a bubble. The following fetch has IF_ID_PC_Plus4=0x00400038.
- Simultaneous redirects: Branch_Taken=1 (target 0x00400080) and Jump_En=1 (target 0x00400100) in the same cycle. PC must become 0x00400080.
- Reset mid-operation: after 5 fetches with Fetch_Count=5, assert reset together with Branch_Taken. PC=0x00400000, all IF_ID_* outputs 0, Fetch_Count=0.

Source files
------------

// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, next-PC selection
// (sequential / jump / branch), the IF/ID pipeline register and a debug
// count of valid fetches.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Jump_En,
    input  logic [31:0] Jump_Target,
    input  logic        Branch_Taken,
    input  logic [31:0] Branch_Target,
    output logic [31:0] Inst_Addr,
    input  logic [31:0] Inst_In,
    output logic [31:0] IF_ID_Inst,
    output logic [31:0] IF_ID_PC_Plus4,
    output logic        IF_ID_Valid,
    output logic [31:0] Fetch_Count
);

    localparam int unsigned XLEN       = 32;
    localparam logic [XLEN-1:0] WORD_MASK = 32'hFFFF_FFFC;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [XLEN-1:0] pc_next;
    logic [XLEN-1:0] inst_next;
    logic [XLEN-1:0] plus4_next;
    logic            valid_next;
    logic [XLEN-1:0] count_next;

    // The PC register is the ROM address; no logic sits after it.
    assign Inst_Addr = pc;
    assign pc_plus4  = pc + PC_STEP;

    // Next-state selection: branch (older, in EX) beats stall, stall beats jump.
    always_comb begin
        pc_next    = pc;
        inst_next  = IF_ID_Inst;
        plus4_next = IF_ID_PC_Plus4;
        valid_next = IF_ID_Valid;
        count_next = Fetch_Count;
        if (Branch_Taken) begin
            pc_next    = Branch_Target & WORD_MASK;
            inst_next  = '0;
            plus4_next = '0;
            valid_next = 1'b0;
        end else if (Stall) begin
            pc_next    = pc;
        end else if (Jump_En) begin
            pc_next    = Jump_Target & WORD_MASK;
            inst_next  = '0;
            plus4_next = '0;
            valid_next = 1'b0;
        end else begin
            pc_next    = pc_plus4;
            inst_next  = Inst_In;
            plus4_next = pc_plus4;
            valid_next = 1'b1;
            count_next = Fetch_Count + XLEN'(1);
        end
    end

    // PC, IF/ID register and fetch counter with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc             <= RESET_PC;
            IF_ID_Inst     <= '0;
            IF_ID_PC_Plus4 <= '0;
            IF_ID_Valid    <= 1'b0;
            Fetch_Count    <= '0;
        end else begin
            pc             <= pc_next;
            IF_ID_Inst     <= inst_next;
            IF_ID_PC_Plus4 <= plus4_next;
            IF_ID_Valid    <= valid_next;
            Fetch_Count    <= count_next;
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed steps from the fetch-stage scenarios followed
// by random redirect/stall traffic against a small behavioural model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Jump_En;
    logic [31:0] Jump_Target;
    logic        Branch_Taken;
    logic [31:0] Branch_Target;
    logic [31:0] Inst_Addr;
    logic [31:0] Inst_In;
    logic [31:0] IF_ID_Inst;
    logic [31:0] IF_ID_PC_Plus4;
    logic        IF_ID_Valid;
    logic [31:0] Fetch_Count;

    // ROM model: instruction word is the address scrambled by a key.
    logic [31:0] rom_key = 32'h0;
    assign Inst_In = Inst_Addr ^ rom_key;

    // Reference state: what the fetch stage should hold after each edge.
    logic [31:0] m_pc, m_inst, m_p4, m_cnt;
    logic        m_valid;

    int checks = 0;
    int errors = 0;

    if_stage #(.RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Jump_En(Jump_En),
        .Jump_Target(Jump_Target), .Branch_Taken(Branch_Taken),
        .Branch_Target(Branch_Target), .Inst_Addr(Inst_Addr), .Inst_In(Inst_In),
        .IF_ID_Inst(IF_ID_Inst), .IF_ID_PC_Plus4(IF_ID_PC_Plus4),
        .IF_ID_Valid(IF_ID_Valid), .Fetch_Count(Fetch_Count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_model(input string tag);
        check({tag, ".pc"},    Inst_Addr,             m_pc);
        check({tag, ".inst"},  IF_ID_Inst,            m_inst);
        check({tag, ".p4"},    IF_ID_PC_Plus4,        m_p4);
        check({tag, ".valid"}, {31'b0, IF_ID_Valid},  {31'b0, m_valid});
        check({tag, ".count"}, Fetch_Count,           m_cnt);
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic cycle(input string tag, input logic r, input logic s,
                         input logic j, input logic [31:0] jt,
                         input logic b, input logic [31:0] bt);
        logic [31:0] fetched;
        reset = r; Stall = s; Jump_En = j; Jump_Target = jt;
        Branch_Taken = b; Branch_Target = bt;
        fetched = m_pc ^ rom_key;
        if (r) begin
            m_pc = RESET_PC; m_inst = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;
        end else if (b) begin
            m_pc = (bt / 4) * 4; m_inst = 0; m_p4 = 0; m_valid = 0;
        end else if (s) begin
            // everything holds
        end else if (j) begin
            m_pc = (jt / 4) * 4; m_inst = 0; m_p4 = 0; m_valid = 0;
        end else begin
            m_inst = fetched; m_p4 = m_pc + 4; m_valid = 1;
            m_cnt = m_cnt + 1; m_pc = m_pc + 4;
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    task automatic run(input string tag);
        cycle(tag, 0, 0, 0, 32'h0, 0, 32'h0);
    endtask

    initial begin
        m_pc = 0; m_inst = 0; m_p4 = 0; m_valid = 0; m_cnt = 0;

        // Reset held two cycles, then free run with ROM returning the address.
        cycle("rst0", 1, 0, 0, 32'h0, 0, 32'h0);
        cycle("rst1", 1, 0, 0, 32'h0, 0, 32'h0);
        check("rst_pc", Inst_Addr, 32'h0040_0000);
        check("rst_cnt", Fetch_Count, 32'h0);
        run("run1");
        check("first_inst", IF_ID_Inst, 32'h0040_0000);
        check("first_p4", IF_ID_PC_Plus4, 32'h0040_0004);
        check("first_valid", {31'b0, IF_ID_Valid}, 32'h1);
        check("first_cnt", Fetch_Count, 32'h1);
        check("pc_4", Inst_Addr, 32'h0040_0004);
        run("run2");
        check("pc_8", Inst_Addr, 32'h0040_0008);
        run("run3");
        check("pc_c", Inst_Addr, 32'h0040_000C);

        // Stall for two cycles holds everything; release moves on.
        cycle("stall1", 0, 1, 0, 32'h0, 0, 32'h0);
        cycle("stall2", 0, 1, 0, 32'h0, 0, 32'h0);
        check("stall_pc", Inst_Addr, 32'h0040_000C);
        check("stall_cnt", Fetch_Count, 32'h3);
        run("unstall");
        check("unstall_pc", Inst_Addr, 32'h0040_0010);

        // Branch overrides stall; target low bits cleared.
        cycle("br_stall", 0, 1, 0, 32'h0, 1, 32'h0040_0043);
        check("br_pc", Inst_Addr, 32'h0040_0040);
        check("br_valid", {31'b0, IF_ID_Valid}, 32'h0);
        check("br_inst", IF_ID_Inst, 32'h0);
        check("br_cnt", Fetch_Count, 32'h4);

        // Jump gated by stall, then taken, then sequential fetch.
        cycle("jmp_stall", 0, 1, 1, 32'h0040_0034, 0, 32'h0);
        check("jmp_hold", Inst_Addr, 32'h0040_0040);
        cycle("jmp_go", 0, 0, 1, 32'h0040_0034, 0, 32'h0);
        check("jmp_pc", Inst_Addr, 32'h0040_0034);
        check("jmp_valid", {31'b0, IF_ID_Valid}, 32'h0);
        run("jmp_next");
        check("jmp_p4", IF_ID_PC_Plus4, 32'h0040_0038);

        // Branch wins over a simultaneous jump.
        cycle("br_jmp", 0, 0, 1, 32'h0040_0100, 1, 32'h0040_0080);
        check("br_jmp_pc", Inst_Addr, 32'h0040_0080);

        // PC wraps past the top of the address space.
        cycle("wrap_jmp", 0, 0, 1, 32'hFFFF_FFFE, 0, 32'h0);
        check("wrap_tgt", Inst_Addr, 32'hFFFF_FFFC);
        run("wrap_run");
        check("wrap_pc", Inst_Addr, 32'h0);
        check("wrap_p4", IF_ID_PC_Plus4, 32'h0);

        // Reset mid-stream beats a simultaneous branch.
        cycle("rst_mid0", 1, 0, 0, 32'h0, 0, 32'h0);
        for (int i = 0; i < 5; i++) run("five");
        check("five_cnt", Fetch_Count, 32'h5);
        cycle("rst_br", 1, 1, 1, 32'h0040_0100, 1, 32'h0040_0080);
        check("rst_br_pc", Inst_Addr, 32'h0040_0000);
        check("rst_br_inst", IF_ID_Inst, 32'h0);
        check("rst_br_p4", IF_ID_PC_Plus4, 32'h0);
        check("rst_br_cnt", Fetch_Count, 32'h0);

        // Random traffic with a scrambled ROM.
        rom_key = 32'h5A5A_C3C3;
        for (int i = 0; i < 400; i++) begin
            logic r, s, j, b;
            logic [31:0] jt, bt;
            r  = ($urandom_range(0, 49) == 0);
            s  = ($urandom_range(0, 3) == 0);
            j  = ($urandom_range(0, 5) == 0);
            b  = ($urandom_range(0, 7) == 0);
            jt = $urandom();
            bt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                             : $urandom();
            if (i % 97 == 0) rom_key = $urandom();
            cycle("rand", r, s, j, jt, b, bt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
